// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: pipeline-wide register-index, width and bubble constants.
package wb_regfile_pkg;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
    localparam int DATA_W_DEF = 32;
    localparam logic ID_EX_BUBBLE = 1'b0;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32-entry 2-read/1-write register array; WB_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    output logic [DATA_W-1:0]    rdata_a,
    output logic [DATA_W-1:0]    rdata_b,
    output logic                 wr_eff
);
    logic [DATA_W-1:0] regs [32];

    assign wr_eff = we && waddr != REG_ZERO;

    // entry 0 is never written, so it reads 0 without a separate guard
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        else if (wr_eff)
            regs[waddr] <= wdata;

`ifdef WB_BYPASS_EN
    assign rdata_a = (wr_eff && waddr == raddr_a) ? wdata : regs[raddr_a];
    assign rdata_b = (wr_eff && waddr == raddr_b) ? wdata : regs[raddr_b];
`else
    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
`endif
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back register file with ID/EX capture and retired-write counter (WB_BYPASS_EN enables write-first read).
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] mem_wb_regdest,
    input  logic                 mem_wb_writereg,
    input  logic [DATA_W-1:0]    mem_wb_wbvalue,
    input  logic [REG_IDX_W-1:0] if_id_rs,
    input  logic [REG_IDX_W-1:0] if_id_rt,
    input  logic                 id_stall,
    input  logic                 id_flush,
    output logic [DATA_W-1:0]    id_ex_rsvalue,
    output logic [DATA_W-1:0]    id_ex_rtvalue,
    output logic [REG_IDX_W-1:0] id_ex_rs,
    output logic [REG_IDX_W-1:0] id_ex_rt,
    output logic [CNT_W-1:0]     wb_commit_count
);
    localparam int IDEX_W = 2 * DATA_W + 2 * REG_IDX_W;
    localparam logic [IDEX_W-1:0] BUBBLE = {IDEX_W{ID_EX_BUBBLE}};

    logic [DATA_W-1:0] rd_a, rd_b;
    logic wr_eff;

    regfile_2r1w #(.DATA_W(DATA_W)) u_rf (
        .clock   (clock),
        .reset   (reset),
        .we      (mem_wb_writereg),
        .waddr   (mem_wb_regdest),
        .wdata   (mem_wb_wbvalue),
        .raddr_a (if_id_rs),
        .raddr_b (if_id_rt),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .wr_eff  (wr_eff)
    );

    // flush beats stall; write-back and its counter never stall
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            {id_ex_rsvalue, id_ex_rtvalue, id_ex_rs, id_ex_rt} <= BUBBLE;
            wb_commit_count <= '0;
        end else begin
            if (id_flush)
                {id_ex_rsvalue, id_ex_rtvalue, id_ex_rs, id_ex_rt} <= BUBBLE;
            else if (!id_stall)
                {id_ex_rsvalue, id_ex_rtvalue, id_ex_rs, id_ex_rt} <= {rd_a, rd_b, if_id_rs, if_id_rt};
            if (wr_eff)
                wb_commit_count <= wb_commit_count + CNT_W'(1);
        end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scoreboard bench for wb_regfile; expectations follow WB_BYPASS_EN.
module tb_wb_regfile;
    logic        clock = 0, reset = 1;
    logic [4:0]  mem_wb_regdest = '0;
    logic        mem_wb_writereg = 0;
    logic [31:0] mem_wb_wbvalue = '0;
    logic [4:0]  if_id_rs = '0, if_id_rt = '0;
    logic        id_stall = 0, id_flush = 0;
    logic [31:0] id_ex_rsvalue, id_ex_rtvalue;
    logic [4:0]  id_ex_rs, id_ex_rt;
    logic [15:0] wb_commit_count;

    wb_regfile dut (
        .clock(clock), .reset(reset),
        .mem_wb_regdest(mem_wb_regdest), .mem_wb_writereg(mem_wb_writereg), .mem_wb_wbvalue(mem_wb_wbvalue),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_stall(id_stall), .id_flush(id_flush),
        .id_ex_rsvalue(id_ex_rsvalue), .id_ex_rtvalue(id_ex_rtvalue),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .wb_commit_count(wb_commit_count)
    );

    always #5 clock = ~clock;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] SAME_CYCLE_17 = 32'h55;
`else
    localparam logic [31:0] SAME_CYCLE_17 = 32'h11;
`endif

    typedef struct {
        int          cyc;
        string       nm;
        logic [89:0] v;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [89:0] act;

    assign act = {id_ex_rsvalue, id_ex_rtvalue, id_ex_rs, id_ex_rt, wb_commit_count};

    task automatic chk(input string nm, input logic [89:0] a, input logic [89:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got rsv=%h rtv=%h rs=%0d rt=%0d cnt=%h, expected rsv=%h rtv=%h rs=%0d rt=%0d cnt=%h",
                     nm, a[89:58], a[57:26], a[25:21], a[20:16], a[15:0],
                     e[89:58], e[57:26], e[25:21], e[20:16], e[15:0]);
        end
    endtask

    // monitor: compares each expectation after the edge it was scheduled for
    initial forever begin
        @(posedge clock);
        cyc++;
        #1;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, act, e.v);
        end
    end

    task automatic step(input string nm, input logic we, input logic [4:0] dst, input logic [31:0] val,
                        input logic [4:0] rs, input logic [4:0] rt, input logic st, input logic fl,
                        input logic check, input logic [31:0] ersv, input logic [31:0] ertv,
                        input logic [4:0] ers, input logic [4:0] ert, input logic [15:0] ecnt);
        mem_wb_writereg = we;
        mem_wb_regdest  = dst;
        mem_wb_wbvalue  = val;
        if_id_rs = rs;
        if_id_rt = rt;
        id_stall = st;
        id_flush = fl;
        if (check) sb.push_back('{cyc + 1, nm, {ersv, ertv, ers, ert, ecnt}});
        @(negedge clock);
    endtask

    initial begin
        #1 reset = 0;
        #1 chk("reset_state", act, '0);
        @(negedge clock);
        @(negedge clock);
        reset = 1;
        step("read_after_reset", 0, 0, 0, 8, 9, 0, 0, 1, 0, 0, 8, 9, 0);
        step("write8", 1, 8, 32'h1414, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        step("write9", 1, 9, 32'h4141, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
        step("read8_9", 0, 0, 0, 8, 9, 0, 0, 1, 32'h1414, 32'h4141, 8, 9, 2);
        step("write0_ignored", 1, 0, 32'hDEADBEEF, 0, 8, 0, 0, 1, 0, 32'h1414, 0, 8, 2);
        step("read0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
        step("write17_old", 1, 17, 32'h11, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
        step("same_cycle_17", 1, 17, 32'h55, 17, 17, 0, 0, 1, SAME_CYCLE_17, SAME_CYCLE_17, 17, 17, 4);
        step("reread17", 0, 0, 0, 17, 8, 0, 0, 1, 32'h55, 32'h1414, 17, 8, 4);
        step("stall1", 1, 9, 32'h99, 9, 9, 1, 0, 1, 32'h55, 32'h1414, 17, 8, 5);
        step("stall2", 1, 10, 32'hA, 10, 9, 1, 0, 1, 32'h55, 32'h1414, 17, 8, 6);
        step("stall3", 1, 11, 32'hB, 11, 10, 1, 0, 1, 32'h55, 32'h1414, 17, 8, 7);
        step("flush_over_stall", 1, 12, 32'hC, 12, 12, 1, 1, 1, 0, 0, 0, 0, 8);
        step("read9_10", 0, 0, 0, 9, 10, 0, 0, 1, 32'h99, 32'hA, 9, 10, 8);
        step("read11_12", 0, 0, 0, 11, 12, 0, 0, 1, 32'hB, 32'hC, 11, 12, 8);
        for (int i = 0; i < 65527; i++)
            step("count_ffff", 1, 1, 32'h7777, 0, 0, 0, 0, i == 65526, 0, 0, 0, 0, 16'hFFFF);
        step("count_wrap", 1, 2, 32'h1234, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
        step("read1_2", 0, 0, 0, 1, 2, 0, 0, 1, 32'h7777, 32'h1234, 1, 2, 0);
        mem_wb_writereg = 1;
        mem_wb_regdest  = 3;
        mem_wb_wbvalue  = 32'h33;
        if_id_rs = 3;
        if_id_rt = 3;
        #2 reset = 0;
        #1 chk("async_reset", act, '0);
        @(negedge clock);
        mem_wb_writereg = 0;
        reset = 1;
        step("post_reset_1_2", 0, 0, 0, 1, 2, 0, 0, 1, 0, 0, 1, 2, 0);
        step("post_reset_3_17", 0, 0, 0, 3, 17, 0, 0, 1, 0, 0, 3, 17, 0);
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations pending, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached, expected end before it", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MIPS pipeline: consumes the MEM/WB register outputs (`mem_wb_regdest`, `mem_wb_writereg`, `mem_wb_wbvalue`) and commits them to a 32x32 general-purpose register file.
- Provides the ID-stage read ports: two source registers are read and registered into the ID/EX pipeline register feeding EX.
- Keeps a retired-write counter for program-level checking.

Parameters:
- DATA_W, 32, register and write-back value width
- CNT_W, 16, width of the retired-write counter

Ports:
- clock  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- mem_wb_regdest  input  5  destination register of the instruction in WB
- mem_wb_writereg  input  1  1: commit mem_wb_wbvalue this cycle
- mem_wb_wbvalue  input  DATA_W  value to commit
- if_id_rs  input  5  source register A index from the IF/ID register
- if_id_rt  input  5  source register B index from the IF/ID register
- id_stall  input  1  1: hold the ID/EX outputs
- id_flush  input  1  1: load a bubble into ID/EX
- id_ex_rsvalue  output  DATA_W  registered value of rs
- id_ex_rtvalue  output  DATA_W  registered value of rt
- id_ex_rs  output  5  registered rs index, for the EX forwarding unit
- id_ex_rt  output  5  registered rt index
- wb_commit_count  output  CNT_W  number of committed register writes

Behaviour:
- Reset (reset=0, asynchronous):
  - all 32 registers = 0
  - id_ex_rsvalue, id_ex_rtvalue = 0
  - id_ex_rs, id_ex_rt = 0
  - wb_commit_count = 0
  - A reset mid-operation discards any in-flight write or ID/EX capture.
- Write:
  - At posedge, if mem_wb_writereg=1 and mem_wb_regdest!=0, then regs[mem_wb_regdest] <= mem_wb_wbvalue.
  - Writes to register 0 are ignored and are not counted.
  - Register 0 always reads 0.
- Read:
  - Combinational read of regs[if_id_rs] and regs[if_id_rt].
  - The result is captured into ID/EX at posedge.
  - Latency: index presented in cycle N appears on id_ex_* after edge N+1.
- ID/EX update at each posedge, in priority order:
  - id_flush=1: all id_ex_* outputs <= 0 (a bubble; flush wins over stall).
  - else id_stall=1: hold all id_ex_* outputs.
  - else: capture the read data and the indices.
- Counter:
  - wb_commit_count increments by 1 on each effective write.
  - Wraps from 2^CNT_W-1 to 0.
  - It still counts while id_stall or id_flush is active; write-back is never stalled.
- Same-cycle write and read of the same register: behaviour is governed by WB_BYPASS_EN (below).
- rs==rt is legal: both outputs carry the same value.

Optional Feature:
- WB_BYPASS_EN defined:
  - Emulates write-first-half/read-second-half.
  - If mem_wb_writereg=1, mem_wb_regdest!=0 and mem_wb_regdest equals if_id_rs (or if_id_rt), the corresponding captured value is mem_wb_wbvalue instead of the array contents.
- Undefined:
  - The captured value is the old array contents.
  - External forwarding or a 3-NOP spacing must cover the hazard.

Decomposition:
- Shared pipeline package holds:
  - REG_ZERO = 5'd0
  - REG_IDX_W = 5
  - DATA_W default
  - the ID/EX bubble constant (all zeros), shared with the EX/MEM and MEM/WB stages
- One natural sub-module: `regfile_2r1w`, holding the register array, the write port with zero-register suppression, the two combinational read ports and the optional bypass mux.
- The top level holds the ID/EX register and the counter.

Test Plan:
- Reset then no writes; rs=8, rt=9 → id_ex_rsvalue=0, id_ex_rtvalue=0, wb_commit_count=0.
- Write regdest=8, value 0x00001414, then regdest=9, value 0x00004141; next cycle rs=8, rt=9 → 0x00001414 / 0x00004141, count=2.
- Write regdest=0, value 0xDEADBEEF, then read rs=0 → 0, count unchanged.
- Same-cycle write reg 17 = 0x55 and read rs=17, old value 0x11:
  - with WB_BYPASS_EN → 0x55
  - without → 0x11
  - both → 0x55 on a re-read next cycle.
- Capture values, then id_stall=1 for 3 cycles while indices and writes change → outputs held and count still increments; then id_flush=1 together with id_stall=1 → all id_ex_* = 0.
- Preload count to 0xFFFF via 65535 writes, then one more write → count=0x0000; assert reset mid-write → all registers and outputs 0 immediately.
